ts_token_sched: RTL

- Time-slot and token-bucket scheduler that gates packet release from the egress queue toward the esw port.
- Consumes the configuration registers produced by the beacon update logic: time_slot_period, token_bucket_para, and the beacon_update_master toggle.
- Generates slot boundaries, refills a token bucket once per slot, and grants one whole packet at a time when enough tokens exist and the slot guard band is not active.
- New configuration takes effect only at a slot boundary.

---
 rtl/ts_token_sched_if.sv | 32 +++
 rtl/ts_token_sched.sv | 106 ++++++++++
 2 files changed

// File: rtl/ts_token_sched_if.sv
// Configuration, queue handshake and status bundle for the time-slot / token-bucket scheduler.
// The slave side belongs to the scheduler; the master side belongs to the update logic and egress queue.
interface ts_token_sched_if #(
  parameter int SLOT_ID_W = 8
);
  logic [31:0]          in_time_slot_period;
  logic [31:0]          in_token_bucket_para;
  logic                 in_beacon_update;
  logic                 in_pkt_req;
  logic [7:0]           in_pkt_len;
  logic                 in_pkt_done;
  logic                 out_pkt_grant;
  logic                 out_slot_pulse;
  logic [SLOT_ID_W-1:0] out_slot_id;
  logic [31:0]          out_tokens;
  logic                 out_gate_open;
  logic                 out_busy;

  modport master (
    output in_time_slot_period, in_token_bucket_para, in_beacon_update,
           in_pkt_req, in_pkt_len, in_pkt_done,
    input  out_pkt_grant, out_slot_pulse, out_slot_id, out_tokens,
           out_gate_open, out_busy
  );

  modport slave (
    input  in_time_slot_period, in_token_bucket_para, in_beacon_update,
           in_pkt_req, in_pkt_len, in_pkt_done,
    output out_pkt_grant, out_slot_pulse, out_slot_id, out_tokens,
           out_gate_open, out_busy
  );
endinterface

// File: rtl/ts_token_sched.sv
// Time-slot and token-bucket scheduler: slot timer, per-slot token refill with boundary-aligned
// config updates, guard band ahead of each boundary, and a one-packet-at-a-time grant FSM.
module ts_token_sched #(
  parameter logic [31:0] BUCKET_MAX = 32'd64,
  parameter logic [15:0] GUARD_CYC  = 16'd8,
  parameter int          SLOT_ID_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  ts_token_sched_if.slave bus
);
  localparam logic [31:0] RST_PERIOD = 32'h0000_7a12;
  localparam logic [31:0] RST_PARA   = 32'd10;
  localparam logic [31:0] GUARD_W    = {16'd0, GUARD_CYC};

  typedef enum logic {IDLE_S, XMIT_S} state_t;

  state_t               state, state_nxt;
  logic                 upd_q, pending;
  logic [31:0]          sh_period, sh_para, act_period, act_para;
  logic [31:0]          slot_cnt, period_eff, tokens, tok_next;
  logic [SLOT_ID_W-1:0] slot_id;
  logic [7:0]           len_eff;
  logic [32:0]          tok_sum;
  logic                 slot_end, gate_open, grant_ok, grant_q, busy;

  assign period_eff = (act_period < 32'd2) ? 32'd2 : act_period;
  assign slot_end   = (slot_cnt == period_eff - 32'd1);
  // A guard band at least as long as the slot would starve the port, so it disables itself.
  assign gate_open  = (GUARD_W >= period_eff) || (slot_cnt < period_eff - GUARD_W);
  assign len_eff    = (bus.in_pkt_len == 8'd0) ? 8'd1 : bus.in_pkt_len;
  assign grant_ok   = (state == IDLE_S) && bus.in_pkt_req && gate_open &&
                      (tokens >= {24'd0, len_eff});

  // Deduct before adding; grant_ok guarantees the subtraction cannot go negative.
  assign tok_sum  = {1'b0, tokens}
                  - (grant_ok ? {25'd0, len_eff} : 33'd0)
                  + (slot_end ? {1'b0, act_para} : 33'd0);
  assign tok_next = (tok_sum > {1'b0, BUCKET_MAX}) ? BUCKET_MAX : tok_sum[31:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q      <= 1'b0;
      pending    <= 1'b0;
      sh_period  <= RST_PERIOD;
      sh_para    <= RST_PARA;
      act_period <= RST_PERIOD;
      act_para   <= RST_PARA;
    end else begin
      upd_q <= bus.in_beacon_update;
      if (bus.in_beacon_update != upd_q) begin
        pending   <= 1'b1;
        sh_period <= bus.in_time_slot_period;
        sh_para   <= bus.in_token_bucket_para;
      end else if (slot_end) begin
        pending <= 1'b0;
      end
      if (slot_end && pending) begin
        act_period <= sh_period;
        act_para   <= sh_para;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      slot_id  <= '0;
      tokens   <= RST_PARA;
      grant_q  <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? 32'd0 : slot_cnt + 32'd1;
      if (slot_end) slot_id <= slot_id + 1'b1;
      tokens  <= tok_next;
      grant_q <= grant_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE_S;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_S:  if (grant_ok)        state_nxt = XMIT_S;
      XMIT_S:  if (bus.in_pkt_done) state_nxt = IDLE_S;
      default:                      state_nxt = IDLE_S;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state == XMIT_S) busy = 1'b1;
  end

  assign bus.out_pkt_grant  = grant_q;
  assign bus.out_slot_pulse = slot_end;
  assign bus.out_slot_id    = slot_id;
  assign bus.out_tokens     = tokens;
  assign bus.out_gate_open  = gate_open;
  assign bus.out_busy       = busy;
endmodule
